// File: rtl/fft_frame_ctrl.sv
// Frame sequencer between an ADC sample stream and a streaming FFT core: loads one frame, waits for and drains the FFT output.
// Latency: every output is registered; an accepted sample appears on ipd/idx_i/fft_din one cycle after adc_valid.
// Backpressure: none; samples outside LOAD are dropped. Optional FFT_DROP_CNT_EN adds a saturating drop_cnt output for those samples.
`timescale 1ns/1ps
module fft_frame_ctrl #(
    parameter int          FRAME_LEN = 1024,
    parameter logic [15:0] TIMEOUT   = 16'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        adc_valid,
    input  logic [15:0] adc_data,
    input  logic        opd_o,
    input  logic [9:0]  idx_o,
    output logic        ipd,
    output logic [31:0] fft_din,
    output logic [9:0]  idx_i,
    output logic        search_en,
    output logic        frame_done,
    output logic        err,
    output logic        busy,
    output logic [15:0] frame_cnt
`ifdef FFT_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    localparam int IDX_W = 10;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        WAIT_OUT = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   smp_cnt;
    logic [15:0]        tmo_cnt;
    logic [IDX_W-1:0]   idx_lat;

    logic               accept;
    logic               last_smp;
    logic               timeout_hit;
    logic               short_frame;

    logic               ipd_nxt;
    logic [31:0]        fft_din_nxt;
    logic [IDX_W-1:0]   idx_i_nxt;
    logic               search_en_nxt;
    logic               frame_done_nxt;
    logic               err_nxt;
    logic               busy_nxt;
    logic [15:0]        frame_cnt_nxt;

    // A sample is only taken while loading; everything else on adc_valid is dropped.
    assign accept      = (state == LOAD) && adc_valid;
    assign last_smp    = accept && (smp_cnt == LAST_IDX);
    // The counter "reaches" TIMEOUT on the edge that ends the TIMEOUT-th waiting cycle.
    assign timeout_hit = (state == WAIT_OUT) && !opd_o && ((tmo_cnt + 16'd1) == TIMEOUT);
    // The FFT stream ended before delivering its final bin.
    assign short_frame = (state == DRAIN) && !opd_o && (idx_lat != LAST_IDX);

    // State register; reset mid-frame simply discards the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; en is only consulted in IDLE and DONE so a frame in flight is never aborted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (en) state_nxt = LOAD;
            LOAD:     if (last_smp) state_nxt = WAIT_OUT;
            WAIT_OUT: begin
                if (opd_o)            state_nxt = DRAIN;
                else if (timeout_hit) state_nxt = IDLE;
            end
            DRAIN:    if (!opd_o) state_nxt = DONE;
            DONE:     state_nxt = en ? LOAD : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Sample index, timeout counter and last-seen output index; counters sit at 0 outside their own state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp_cnt <= '0;
            tmo_cnt <= '0;
            idx_lat <= '0;
        end else begin
            if (state != LOAD)  smp_cnt <= '0;
            else if (accept)    smp_cnt <= smp_cnt + 10'd1;

            if (state != WAIT_OUT) tmo_cnt <= '0;
            else                   tmo_cnt <= tmo_cnt + 16'd1;

            if (((state == WAIT_OUT) || (state == DRAIN)) && opd_o) idx_lat <= idx_o;
        end
    end

    // Next values for the registered outputs; state-derived flags follow the state being entered.
    always_comb begin
        ipd_nxt        = accept;
        idx_i_nxt      = accept ? smp_cnt : idx_i;
        fft_din_nxt    = accept ? {adc_data, 16'h0000} : fft_din;
        search_en_nxt  = (state_nxt == DRAIN);
        frame_done_nxt = (state_nxt == DONE);
        err_nxt        = timeout_hit || short_frame;
        busy_nxt       = (state_nxt != IDLE);
        frame_cnt_nxt  = frame_done_nxt ? (frame_cnt + 16'd1) : frame_cnt;
    end

    // Output register stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ipd        <= 1'b0;
            idx_i      <= '0;
            fft_din    <= '0;
            search_en  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            ipd        <= ipd_nxt;
            idx_i      <= idx_i_nxt;
            fft_din    <= fft_din_nxt;
            search_en  <= search_en_nxt;
            frame_done <= frame_done_nxt;
            err        <= err_nxt;
            busy       <= busy_nxt;
            frame_cnt  <= frame_cnt_nxt;
        end
    end

`ifdef FFT_DROP_CNT_EN
    // Count samples that arrive while not loading; sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (adc_valid && (state != LOAD) && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
`timescale 1ns/1ps
module tb_fft_frame_ctrl;

    localparam int FRAME_LEN = 1024;
    localparam int TIMEOUT   = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        adc_valid;
    logic [15:0] adc_data;
    logic        opd_o;
    logic [9:0]  idx_o;
    logic        ipd;
    logic [31:0] fft_din;
    logic [9:0]  idx_i;
    logic        search_en;
    logic        frame_done;
    logic        err;
    logic        busy;
    logic [15:0] frame_cnt;
`ifdef FFT_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int n_ipd    = 0;
    int n_fd     = 0;
    int n_err    = 0;
    int n_both   = 0;

    // Expected registered outputs for one cycle.
    typedef struct packed {
        logic        ipd;
        logic [9:0]  idx;
        logic [31:0] din;
        logic        se;
        logic        fd;
        logic        er;
        logic        bz;
        logic [15:0] fc;
    } exp_t;

    exp_t expq[$];
    exp_t cur;

    // Model state: last forwarded sample and completed-frame count.
    logic [9:0]  m_idx = '0;
    logic [31:0] m_din = '0;
    logic [15:0] m_fc  = '0;

    fft_frame_ctrl #(
        .FRAME_LEN (FRAME_LEN),
        .TIMEOUT   (16'd4096)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .opd_o      (opd_o),
        .idx_o      (idx_o),
        .ipd        (ipd),
        .fft_din    (fft_din),
        .idx_i      (idx_i),
        .search_en  (search_en),
        .frame_done (frame_done),
        .err        (err),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
`ifdef FFT_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] smp(input int i);
        logic [31:0] t;
        t = i * 613 + 32'h8123;
        return t[15:0];
    endfunction

    function automatic exp_t mk(input logic ipd_e, input logic se_e, input logic fd_e,
                                input logic er_e, input logic bz_e);
        exp_t e;
        e.ipd = ipd_e;
        e.idx = m_idx;
        e.din = m_din;
        e.se  = se_e;
        e.fd  = fd_e;
        e.er  = er_e;
        e.bz  = bz_e;
        e.fc  = m_fc;
        return e;
    endfunction

    // One clock: inputs already applied; e is what the outputs must show after this edge.
    task automatic step(input exp_t e);
        @(posedge clk);
        expq.push_back(e);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Compare process plus pulse monitors, away from the active edge.
    always @(negedge clk) begin
        if (ipd)               n_ipd  = n_ipd + 1;
        if (frame_done)        n_fd   = n_fd + 1;
        if (err)               n_err  = n_err + 1;
        if (err && frame_done) n_both = n_both + 1;
        if (expq.size() > 0) begin
            cur = expq.pop_front();
            chk("ipd",        32'(ipd),        32'(cur.ipd));
            chk("idx_i",      32'(idx_i),      32'(cur.idx));
            chk("fft_din",    fft_din,         cur.din);
            chk("search_en",  32'(search_en),  32'(cur.se));
            chk("frame_done", 32'(frame_done), 32'(cur.fd));
            chk("err",        32'(err),        32'(cur.er));
            chk("busy",       32'(busy),       32'(cur.bz));
            chk("frame_cnt",  32'(frame_cnt),  32'(cur.fc));
        end
    end

    // Load a frame; optional gap cycles (with opd_o noise), en dropped at en_low_at, stop early after stop_at.
    task automatic load_frame(input int gap_every, input int en_low_at, input bit opd_noise, input int stop_at);
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (gap_every > 0 && (i % gap_every) == 0) begin
                adc_valid = 1'b0;
                opd_o     = opd_noise;
                idx_o     = 10'd5;
                step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
                opd_o     = 1'b0;
            end
            if (i == en_low_at) en = 1'b0;
            adc_valid = 1'b1;
            adc_data  = smp(i);
            m_idx     = 10'(i);
            m_din     = {smp(i), 16'h0000};
            step(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
            if (i == stop_at) return;
        end
        adc_valid = 1'b0;
    endtask

    // Wait gap cycles (with some ignored adc_valid pulses), stream n_out FFT bins, finish the frame.
    task automatic drain(input int gap, input int n_out, input bit en_after, input int pulses);
        opd_o = 1'b0;
        for (int g = 0; g < gap; g++) begin
            adc_valid = (g < 2 * pulses) && ((g % 2) == 0);
            adc_data  = 16'hDEAD;
            step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        adc_valid = 1'b0;
        for (int j = 0; j < n_out; j++) begin
            opd_o = 1'b1;
            idx_o = 10'(j);
            step(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        end
        opd_o = 1'b0;
        idx_o = 10'd0;
        en    = en_after;
        m_fc  = m_fc + 16'd1;
        step(mk(1'b0, 1'b0, 1'b1, (n_out != FRAME_LEN), 1'b1));
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, en_after));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ipd"},        32'(ipd),        32'd0);
        chk({tag, "_fft_din"},    fft_din,         32'd0);
        chk({tag, "_idx_i"},      32'(idx_i),      32'd0);
        chk({tag, "_search_en"},  32'(search_en),  32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_err"},        32'(err),        32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_frame_cnt"},  32'(frame_cnt),  32'd0);
`ifdef FFT_DROP_CNT_EN
        chk({tag, "_drop_cnt"},   32'(drop_cnt),   32'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; adc_valid = 1'b0; adc_data = '0; opd_o = 1'b0; idx_o = '0;
        #2 rst = 1'b0;
        #1 chk_all_zero("reset");
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;

        // IDLE ignores samples and FFT output while en is low.
        adc_valid = 1'b1; opd_o = 1'b1; adc_data = 16'h1234;
        for (int k = 0; k < 4; k++) step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        adc_valid = 1'b0; opd_o = 1'b0;

        // Frame 1: back-to-back samples, clean full FFT output.
        en = 1'b1; adc_valid = 1'b1; adc_data = 16'hBEEF;
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        load_frame(0, -1, 1'b0, -1);
        settle();
        chk("f1_last_idx",  32'(idx_i),          32'd1023);
        chk("f1_din_im",    32'(fft_din[15:0]),  32'd0);
        chk("f1_wait_busy", 32'(busy),           32'd1);
        chk("f1_ipd_count", n_ipd,               32'd1024);
        drain(3, FRAME_LEN, 1'b1, 0);
        settle();
        chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("f1_done_cnt",  n_fd,           32'd1);
        chk("f1_err_cnt",   n_err,          32'd0);

        // Frame 2: gaps with opd_o noise, en dropped mid-frame, then no FFT output -> timeout.
        load_frame(7, 100, 1'b1, -1);
        opd_o = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (k == TIMEOUT) step(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            else              step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        settle();
        chk("tmo_err_cnt",   n_err,          32'd1);
        chk("tmo_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("tmo_idle",      32'(busy),      32'd0);

        // Frame 3: output stream stops after idx 500 -> err together with frame_done.
        en = 1'b1;
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        load_frame(0, -1, 1'b0, -1);
        drain(0, 501, 1'b1, 0);
        settle();
        chk("short_both",      n_both,         32'd1);
        chk("short_done_cnt",  n_fd,           32'd2);
        chk("short_frame_cnt", 32'(frame_cnt), 32'd2);

        // Frame 4: reset after sample 300, then restart from index 0.
        load_frame(0, -1, 1'b0, 300);
        settle();
        chk("pre_rst_idx", 32'(idx_i), 32'd300);
        adc_valid = 1'b0;
        rst = 1'b0;
        #1 chk_all_zero("midrst");
        m_idx = '0; m_din = '0; m_fc = '0;
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        load_frame(0, -1, 1'b0, -1);
        drain(20, FRAME_LEN, 1'b0, 10);
        settle();
        chk("final_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("final_done_cnt",  n_fd,           32'd3);
        chk("final_err_cnt",   n_err,          32'd2);
`ifdef FFT_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'd10);
`endif
        repeat (2) settle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
